// File: rtl/rob_commit_pkg.sv
// Shared defines for the reorder-buffer commit slice.
// Holds entry-kind encodings, register-index and data widths.
package rob_commit_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int REG_W      = 5;
    localparam int MaxReg     = (1 << REG_W) - 1;

    typedef enum logic [1:0] {
        KIND_REG    = 2'd0,
        KIND_BRANCH = 2'd1,
        KIND_STORE  = 2'd2,
        KIND_NODEST = 2'd3
    } rob_kind_e;

endpackage

// File: rtl/rob_entry_ram.sv
// ROB entry storage.
// Write port 1: allocation at alloc_idx (valid=1, ready=0, kind, rd).
// Write port 2: writeback at wb_idx (ready, value, mispredict, target);
//               ignored when the addressed entry is not valid.
// retire_we clears the valid bit of the head entry; clear_all drops every entry.
// Head entry is read combinationally.
// With ROB_OPERAND_FWD_EN defined, two extra combinational read ports
// (q1_idx/q2_idx) return ready/value for operand lookup.
module rob_entry_ram
    import rob_commit_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_all,
    input  logic                  alloc_we,
    input  logic [TAG_W-1:0]      alloc_idx,
    input  rob_kind_e             alloc_kind,
    input  logic [REG_W-1:0]      alloc_rd,
    input  logic                  wb_we,
    input  logic [TAG_W-1:0]      wb_idx,
    input  logic [DATA_WIDTH-1:0] wb_value,
    input  logic                  wb_mispredict,
    input  logic [DATA_WIDTH-1:0] wb_target,
    input  logic                  retire_we,
    input  logic [TAG_W-1:0]      head_idx,
    output logic                  head_valid,
    output logic                  head_ready,
    output rob_kind_e             head_kind,
    output logic [REG_W-1:0]      head_rd,
    output logic [DATA_WIDTH-1:0] head_value,
    output logic                  head_mispredict,
    output logic [DATA_WIDTH-1:0] head_target
`ifdef ROB_OPERAND_FWD_EN
    ,
    input  logic [TAG_W-1:0]      q1_idx,
    input  logic [TAG_W-1:0]      q2_idx,
    output logic                  q1_rdy,
    output logic [DATA_WIDTH-1:0] q1_val,
    output logic                  q2_rdy,
    output logic [DATA_WIDTH-1:0] q2_val
`endif
);

    logic [DEPTH-1:0]      valid;
    logic [DEPTH-1:0]      ready;
    rob_kind_e             kind       [DEPTH];
    logic [REG_W-1:0]      rd         [DEPTH];
    logic [DATA_WIDTH-1:0] value      [DEPTH];
    logic [DEPTH-1:0]      mispredict;
    logic [DATA_WIDTH-1:0] target     [DEPTH];

    logic wb_hit;
    assign wb_hit = wb_we && valid[wb_idx];

    always_ff @(posedge clk) begin
        if (rst || clear_all) begin
            valid <= '0;
            ready <= '0;
        end else begin
            if (retire_we) valid[head_idx] <= 1'b0;
            if (alloc_we) begin
                valid[alloc_idx] <= 1'b1;
                ready[alloc_idx] <= 1'b0;
            end
            if (wb_hit) ready[wb_idx] <= 1'b1;
        end
    end

    // Payload carries no reset: it is only observed through valid/ready.
    always_ff @(posedge clk) begin
        if (alloc_we) begin
            kind[alloc_idx] <= alloc_kind;
            rd[alloc_idx]   <= alloc_rd;
        end
        if (wb_hit) begin
            value[wb_idx]      <= wb_value;
            mispredict[wb_idx] <= wb_mispredict;
            target[wb_idx]     <= wb_target;
        end
    end

    assign head_valid      = valid[head_idx];
    assign head_ready      = ready[head_idx];
    assign head_kind       = kind[head_idx];
    assign head_rd         = rd[head_idx];
    assign head_value      = value[head_idx];
    assign head_mispredict = mispredict[head_idx];
    assign head_target     = target[head_idx];

`ifdef ROB_OPERAND_FWD_EN
    assign q1_rdy = ready[q1_idx];
    assign q1_val = value[q1_idx];
    assign q2_rdy = ready[q2_idx];
    assign q2_val = value[q2_idx];
`endif

endmodule

// File: rtl/rob_commit.sv
// Reorder buffer with in-order commit.
// Allocates entries at the tail, accepts CDB writebacks by tag, and retires
// at most one ready head entry per cycle: register writes go to the register
// file, stores are released to the LSB, mispredicted branches flush everything.
// Ports: clk/rst (sync, active-high), rdy (freeze when low), alloc_* (issue),
//        wb_* (CDB), commit_* / rf_* (register file), store_commit (LSB),
//        flush/flush_pc (all units), count (occupancy).
// Optional: ROB_OPERAND_FWD_EN adds q1/q2 operand lookup ports with CDB bypass.
module rob_commit
    import rob_commit_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int TAG_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  alloc_valid,
    output logic                  alloc_ready,
    output logic [TAG_W-1:0]      alloc_tag,
    input  logic [1:0]            alloc_kind,
    input  logic [REG_W-1:0]      alloc_rd,
    input  logic                  wb_valid,
    input  logic [TAG_W-1:0]      wb_tag,
    input  logic [DATA_WIDTH-1:0] wb_value,
    input  logic                  wb_mispredict,
    input  logic [DATA_WIDTH-1:0] wb_target,
    output logic                  commit_valid,
    output logic [REG_W-1:0]      commit_rd,
    output logic [DATA_WIDTH-1:0] commit_value,
    input  logic                  rf_busy_commit_rd,
    input  logic [TAG_W-1:0]      rf_reorder_commit_rd,
    output logic                  commit_clear_busy,
    output logic                  store_commit,
    output logic                  flush,
    output logic [DATA_WIDTH-1:0] flush_pc,
    output logic [TAG_W:0]        count
`ifdef ROB_OPERAND_FWD_EN
    ,
    input  logic [TAG_W-1:0]      q1_tag,
    input  logic [TAG_W-1:0]      q2_tag,
    output logic                  q1_ready,
    output logic [DATA_WIDTH-1:0] q1_value,
    output logic                  q2_ready,
    output logic [DATA_WIDTH-1:0] q2_value
`endif
);

    logic [TAG_W-1:0]      head_ptr;
    logic [TAG_W-1:0]      tail_ptr;
    logic [TAG_W:0]        count_nxt;

    logic                  head_valid;
    logic                  head_ready;
    rob_kind_e             head_kind;
    logic [REG_W-1:0]      head_rd;
    logic [DATA_WIDTH-1:0] head_value;
    logic                  head_mispredict;
    logic [DATA_WIDTH-1:0] head_target;

    logic                  commit_fire;
    logic                  alloc_fire;
    logic                  wb_fire;

    assign commit_fire = head_valid && head_ready && rdy && !rst;

    assign flush        = commit_fire && (head_kind == KIND_BRANCH) && head_mispredict;
    assign flush_pc     = flush ? head_target : '0;
    assign commit_valid = commit_fire && (head_kind == KIND_REG);
    assign commit_rd    = head_rd;
    assign commit_value = head_value;
    assign store_commit = commit_fire && (head_kind == KIND_STORE);
    assign commit_clear_busy = commit_valid && rf_busy_commit_rd
                               && (rf_reorder_commit_rd == head_ptr);

    // Capacity is judged on current occupancy; a slot freed by this cycle's
    // commit is not reusable until the next cycle.
    assign alloc_ready = (count < (TAG_W+1)'(DEPTH)) && !flush;
    assign alloc_tag   = tail_ptr;
    assign alloc_fire  = alloc_valid && alloc_ready && rdy && !rst;
    assign wb_fire     = wb_valid && rdy && !flush && !rst;

    assign count_nxt = count + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(commit_fire);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (alloc_fire)  tail_ptr <= tail_ptr + 1'b1;
            if (commit_fire) head_ptr <= head_ptr + 1'b1;
            count <= count_nxt;
        end
    end

`ifdef ROB_OPERAND_FWD_EN
    logic                  q1_rdy_ram;
    logic [DATA_WIDTH-1:0] q1_val_ram;
    logic                  q2_rdy_ram;
    logic [DATA_WIDTH-1:0] q2_val_ram;
    logic                  q1_bypass;
    logic                  q2_bypass;

    // A result on the CDB this cycle is forwarded before it lands in the RAM.
    assign q1_bypass = wb_valid && (wb_tag == q1_tag);
    assign q2_bypass = wb_valid && (wb_tag == q2_tag);
    assign q1_ready  = q1_bypass || q1_rdy_ram;
    assign q1_value  = q1_bypass ? wb_value : q1_val_ram;
    assign q2_ready  = q2_bypass || q2_rdy_ram;
    assign q2_value  = q2_bypass ? wb_value : q2_val_ram;
`endif

    rob_entry_ram #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) u_entry_ram (
        .clk             (clk),
        .rst             (rst),
        .clear_all       (flush),
        .alloc_we        (alloc_fire),
        .alloc_idx       (tail_ptr),
        .alloc_kind      (rob_kind_e'(alloc_kind)),
        .alloc_rd        (alloc_rd),
        .wb_we           (wb_fire),
        .wb_idx          (wb_tag),
        .wb_value        (wb_value),
        .wb_mispredict   (wb_mispredict),
        .wb_target       (wb_target),
        .retire_we       (commit_fire),
        .head_idx        (head_ptr),
        .head_valid      (head_valid),
        .head_ready      (head_ready),
        .head_kind       (head_kind),
        .head_rd         (head_rd),
        .head_value      (head_value),
        .head_mispredict (head_mispredict),
        .head_target     (head_target)
`ifdef ROB_OPERAND_FWD_EN
        ,
        .q1_idx          (q1_tag),
        .q2_idx          (q2_tag),
        .q1_rdy          (q1_rdy_ram),
        .q1_val          (q1_val_ram),
        .q2_rdy          (q2_rdy_ram),
        .q2_val          (q2_val_ram)
`endif
    );

endmodule

// File: tb/tb_rob_commit.sv
// Directed testbench for rob_commit (default build, DEPTH=16).
module tb_rob_commit;

    localparam int DEPTH = 16;
    localparam int TAG_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              rdy;
    logic              alloc_valid;
    logic              alloc_ready;
    logic [TAG_W-1:0]  alloc_tag;
    logic [1:0]        alloc_kind;
    logic [4:0]        alloc_rd;
    logic              wb_valid;
    logic [TAG_W-1:0]  wb_tag;
    logic [31:0]       wb_value;
    logic              wb_mispredict;
    logic [31:0]       wb_target;
    logic              commit_valid;
    logic [4:0]        commit_rd;
    logic [31:0]       commit_value;
    logic              rf_busy_commit_rd;
    logic [TAG_W-1:0]  rf_reorder_commit_rd;
    logic              commit_clear_busy;
    logic              store_commit;
    logic              flush;
    logic [31:0]       flush_pc;
    logic [TAG_W:0]    count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rob_commit #(.DEPTH(DEPTH)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .rdy                  (rdy),
        .alloc_valid          (alloc_valid),
        .alloc_ready          (alloc_ready),
        .alloc_tag            (alloc_tag),
        .alloc_kind           (alloc_kind),
        .alloc_rd             (alloc_rd),
        .wb_valid             (wb_valid),
        .wb_tag               (wb_tag),
        .wb_value             (wb_value),
        .wb_mispredict        (wb_mispredict),
        .wb_target            (wb_target),
        .commit_valid         (commit_valid),
        .commit_rd            (commit_rd),
        .commit_value         (commit_value),
        .rf_busy_commit_rd    (rf_busy_commit_rd),
        .rf_reorder_commit_rd (rf_reorder_commit_rd),
        .commit_clear_busy    (commit_clear_busy),
        .store_commit         (store_commit),
        .flush                (flush),
        .flush_pc             (flush_pc),
        .count                (count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alloc_valid = 1'b0; alloc_kind = 2'd0; alloc_rd = 5'd0;
        wb_valid = 1'b0; wb_tag = '0; wb_value = '0;
        wb_mispredict = 1'b0; wb_target = '0;
        rf_busy_commit_rd = 1'b0; rf_reorder_commit_rd = '0;
        rdy = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic alloc(input logic [1:0] kind, input logic [4:0] rd, input logic [TAG_W-1:0] exp_tag, input string tag);
        alloc_valid = 1'b1; alloc_kind = kind; alloc_rd = rd;
        #1;
        check(tag, 32'(alloc_tag), 32'(exp_tag));
        step();
        alloc_valid = 1'b0;
    endtask

    task automatic wb(input logic [TAG_W-1:0] t, input logic [31:0] v, input logic misp, input logic [31:0] tgt);
        wb_valid = 1'b1; wb_tag = t; wb_value = v; wb_mispredict = misp; wb_target = tgt;
        step();
        wb_valid = 1'b0; wb_mispredict = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;

        // Reset state, plus reset beating a concurrent alloc.
        alloc_valid = 1'b1;
        step();
        step();
        alloc_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("rst_alloc_ready", 32'(alloc_ready), 32'd1);
        check("rst_alloc_tag",   32'(alloc_tag),   32'd0);
        check("rst_count",       32'(count),       32'd0);
        check("rst_commit_valid",32'(commit_valid),32'd0);
        check("rst_flush",       32'(flush),       32'd0);
        check("rst_flush_pc",    flush_pc,         32'd0);
        check("rst_store",       32'(store_commit),32'd0);

        // Single reg write, rf tag matches -> clear busy.
        alloc(2'd0, 5'd5, 4'd0, "t23_tag");
        wb_valid = 1'b1; wb_tag = 4'd0; wb_value = 32'h2A;
        #1;
        check("t23_no_early_commit", 32'(commit_valid), 32'd0);
        step();
        wb_valid = 1'b0;
        rf_busy_commit_rd = 1'b1; rf_reorder_commit_rd = 4'd0;
        #1;
        check("t23_commit_valid", 32'(commit_valid), 32'd1);
        check("t23_commit_rd",    32'(commit_rd),    32'd5);
        check("t23_commit_value", commit_value,      32'h2A);
        check("t23_clear_busy",   32'(commit_clear_busy), 32'd1);
        step();
        check("t23_count_after",  32'(count), 32'd0);
        check("t23_idle_commit",  32'(commit_valid), 32'd0);

        // Same flow at tag 1, rf tag points elsewhere -> no clear.
        alloc(2'd0, 5'd5, 4'd1, "t24_tag");
        wb(4'd1, 32'h2A, 1'b0, 32'd0);
        rf_busy_commit_rd = 1'b1; rf_reorder_commit_rd = 4'd3;
        #1;
        check("t24_commit_valid", 32'(commit_valid), 32'd1);
        check("t24_clear_busy",   32'(commit_clear_busy), 32'd0);
        step();
        rf_busy_commit_rd = 1'b0;

        // Out-of-order writeback, in-order commit.
        do_reset();
        alloc(2'd0, 5'd1, 4'd0, "t25_tag0");
        alloc(2'd0, 5'd2, 4'd1, "t25_tag1");
        alloc(2'd0, 5'd3, 4'd2, "t25_tag2");
        wb(4'd2, 32'h22, 1'b0, 32'd0);
        wb(4'd1, 32'h11, 1'b0, 32'd0);
        check("t25_blocked_commit", 32'(commit_valid), 32'd0);
        check("t25_blocked_count",  32'(count), 32'd3);
        wb(4'd0, 32'h10, 1'b0, 32'd0);
        check("t25_c0_valid", 32'(commit_valid), 32'd1);
        check("t25_c0_rd",    32'(commit_rd),    32'd1);
        check("t25_c0_value", commit_value,      32'h10);
        step();
        check("t25_c1_valid", 32'(commit_valid), 32'd1);
        check("t25_c1_rd",    32'(commit_rd),    32'd2);
        check("t25_c1_value", commit_value,      32'h11);
        step();
        check("t25_c2_valid", 32'(commit_valid), 32'd1);
        check("t25_c2_rd",    32'(commit_rd),    32'd3);
        check("t25_c2_value", commit_value,      32'h22);
        step();
        check("t25_empty_commit", 32'(commit_valid), 32'd0);
        check("t25_empty_count",  32'(count), 32'd0);

        // Fill, full backpressure, commit frees one slot next cycle, tail wraps.
        do_reset();
        for (int i = 0; i < DEPTH; i++) alloc(2'd3, 5'd0, TAG_W'(i), "t26_fill_tag");
        check("t26_full_count", 32'(count), 32'd16);
        check("t26_full_ready", 32'(alloc_ready), 32'd0);
        wb(4'd0, 32'h5, 1'b0, 32'd0);
        alloc_valid = 1'b1; alloc_kind = 2'd0;
        #1;
        check("t26_nodest_no_strobe", 32'(commit_valid), 32'd0);
        check("t26_same_cycle_ready", 32'(alloc_ready), 32'd0);
        step();
        alloc_valid = 1'b0;
        #1;
        check("t26_count_15",  32'(count), 32'd15);
        check("t26_ready_back",32'(alloc_ready), 32'd1);
        check("t26_tail_wrap", 32'(alloc_tag), 32'd0);

        // Store release.
        do_reset();
        alloc(2'd2, 5'd4, 4'd0, "st_tag");
        wb(4'd0, 32'h0, 1'b0, 32'd0);
        check("st_store_commit", 32'(store_commit), 32'd1);
        check("st_no_reg_write", 32'(commit_valid), 32'd0);
        step();

        // Mispredicted branch flushes younger entry.
        do_reset();
        alloc(2'd1, 5'd0, 4'd0, "t27_tag0");
        alloc(2'd0, 5'd7, 4'd1, "t27_tag1");
        wb(4'd0, 32'h0, 1'b1, 32'h1000);
        wb_valid = 1'b1; wb_tag = 4'd1; wb_value = 32'h5;
        #1;
        check("t27_flush",       32'(flush), 32'd1);
        check("t27_flush_pc",    flush_pc, 32'h1000);
        check("t27_alloc_block", 32'(alloc_ready), 32'd0);
        check("t27_no_commit",   32'(commit_valid), 32'd0);
        step();
        wb_valid = 1'b0;
        #1;
        check("t27_count_zero",  32'(count), 32'd0);
        check("t27_flush_off",   32'(flush), 32'd0);
        check("t27_pc_zero",     flush_pc, 32'd0);
        check("t27_tag1_gone",   32'(commit_valid), 32'd0);
        step();
        check("t27_tag1_gone2",  32'(commit_valid), 32'd0);
        check("t27_tail_reset",  32'(alloc_tag), 32'd0);

        // Freeze with rdy low.
        do_reset();
        alloc(2'd0, 5'd9, 4'd0, "t28_tag");
        wb(4'd0, 32'h77, 1'b0, 32'd0);
        rdy = 1'b0;
        alloc_valid = 1'b1;
        #1;
        check("t28_frozen_commit", 32'(commit_valid), 32'd0);
        step();
        step();
        alloc_valid = 1'b0;
        #1;
        check("t28_frozen_count", 32'(count), 32'd1);
        check("t28_frozen_tail",  32'(alloc_tag), 32'd1);
        rdy = 1'b1;
        #1;
        check("t28_resume_commit", 32'(commit_valid), 32'd1);
        check("t28_resume_value",  commit_value, 32'h77);
        step();
        check("t28_resume_count",  32'(count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rob_commit.md
ROB_COMMIT -- requirements
Module: rob_commit

Interface
REQ-001 SHALL have parameter DEPTH, 16, ROB entry count (power of two, 4..64).
REQ-002 SHALL have localparam TAG_W, $clog2(DEPTH), ROB tag width.
REQ-003 SHALL have ports, in order:
 clk  in  1  clock
 rst  in  1  reset, synchronous, active-high
 rdy  in  1  global enable; low = freeze all state
 alloc_valid  in  1  issue stage allocates an entry
 alloc_ready  out  1  entry available
 alloc_tag  out  TAG_W  tag (tail index) given to this allocation
 alloc_kind  in  2  0=reg write, 1=branch, 2=store, 3=no-dest
 alloc_rd  in  5  destination register
 wb_valid  in  1  CDB writeback
 wb_tag  in  TAG_W  completing entry
 wb_value  in  32  result value
 wb_mispredict  in  1  branch resolved wrong
 wb_target  in  32  correct branch PC
 commit_valid  out  1  register-file write strobe
 commit_rd  out  5  register being committed
 commit_value  out  32  committed value
 rf_busy_commit_rd  in  1  register-file busy bit of commit_rd
 rf_reorder_commit_rd  in  TAG_W  register-file tag of commit_rd
 commit_clear_busy  out  1  register file clears busy of commit_rd
 store_commit  out  1  LSB may perform head store
 flush  out  1  clear-all to every unit
 flush_pc  out  32  refetch PC
 count  out  TAG_W+1  occupied entries

Function
REQ-004 Each entry SHALL hold valid, ready, kind, rd, value, mispredict, target; head/tail pointers TAG_W bits, wrap modulo DEPTH.
REQ-005 alloc_ready SHALL be (count < DEPTH) && !flush; a same-cycle commit does not free a slot for allocation.
REQ-006 alloc_valid && alloc_ready && rdy SHALL, at the edge, write tail entry (valid=1, ready=0), advance tail, increment count; alloc_tag SHALL equal tail combinationally.
REQ-007 wb_valid && rdy SHALL, at the edge, set ready, value, mispredict, target of entry wb_tag; wb to an invalid entry SHALL be ignored.
REQ-008 Writeback SHALL become visible to commit one cycle later (head commits at earliest cycle after wb).
REQ-009 Commit condition C = head valid && head ready && rdy && !rst; all commit outputs combinational from head state and C.
REQ-010 commit_valid SHALL equal C && kind==0; commit_rd/commit_value SHALL present head rd/value; rd==0 still strobes (register file ignores x0).
REQ-011 commit_clear_busy SHALL equal commit_valid && rf_busy_commit_rd && rf_reorder_commit_rd==head tag.
REQ-012 store_commit SHALL equal C && kind==2.
REQ-013 flush SHALL equal C && kind==1 && head mispredict; flush_pc = head target; otherwise flush_pc = 0.
REQ-014 On C the head SHALL advance and count decrement at the edge; simultaneous alloc and commit SHALL leave count unchanged.
REQ-015 On flush, at the edge, all valid bits, head, tail, count SHALL go to 0; same-cycle alloc and wb SHALL be discarded.
REQ-016 One commit per cycle maximum; empty ROB SHALL produce no commit outputs.

Reset
REQ-017 rst SHALL clear all valid/ready bits, head=tail=0, count=0; all outputs 0 except alloc_ready=1, alloc_tag=0.
REQ-018 rst SHALL take priority over rdy, flush, alloc, wb.

Configuration
REQ-019 With ROB_OPERAND_FWD_EN defined, SHALL add ports q1_tag/q2_tag in TAG_W, q1_ready/q2_ready out 1, q1_value/q2_value out 32: combinational entry ready/value lookup, also returning ready=1 and wb_value when wb_valid && wb_tag matches.
REQ-020 Without ROB_OPERAND_FWD_EN, those ports SHALL not exist and no lookup logic SHALL be built.

Structure
REQ-021 Kind encodings, register-index width 5, data width 32 SHALL live in the shared defines package alongside DATA_WIDTH/MaxReg.
REQ-022 Entry storage SHALL be a sub-module rob_entry_ram (one write port alloc, one write port wb, combinational head read); pointer/count logic stays in rob_commit.

Verification
REQ-023 Reset, alloc rd=5 kind=0 tag 0, wb tag0 value 0x2A -> next cycle commit_valid=1, commit_rd=5, commit_value=0x2A; rf_reorder=0, rf_busy=1 -> commit_clear_busy=1.
REQ-024 Same as 023 with rf_reorder=3 -> commit_valid=1, commit_clear_busy=0.
REQ-025 Alloc tags 0,1,2; wb tag2 then tag1 -> no commit until tag0 wb; then commits 0,1,2 on consecutive cycles in order.
REQ-026 Fill DEPTH=16 entries -> alloc_ready=0, count=16; commit one -> alloc_ready=1 next cycle; tail wraps to tag 0.
REQ-027 Alloc branch tag0 + reg tag1, wb both, tag0 mispredict target 0x1000 -> flush=1, flush_pc=0x1000 one cycle, then count=0, tag1 never commits.
REQ-028 rdy=0 with head ready -> no commit outputs, state frozen; rdy=1 -> commit proceeds.
